axi_burst_read_responder: RTL and testbench
===========================================

// Module: axi_burst_read_responder
// PURPOSE
// - AXI4 read-channel responder (slave side) backed by an internal word memory.
// - Serves the cache line-fill bursts: one AR handshake, then arlen+1 R beats with rlast.
// - Acts as the memory model behind the fetch cache in simulation, and as a simple on-chip ROM/RAM.
// - Preloaded through a one-cycle backdoor write port.
// PARAMETERS
// - ADDR_WIDTH    64    byte-address width of araddr
// - DATA_WIDTH    64    R beat width; beat = 8 bytes, only arsize=3 is legal
// - MEM_WORDS     1024  memory depth in DATA_WIDTH words; power of 2
// - READ_LATENCY  2     idle cycles between AR handshake and first rvalid (0..15)
// PORTS
// - clock          in   1           rising-edge clock
// - reset          in   1           synchronous, active-high
// - s_axi_arvalid  in   1           read address valid
// - s_axi_arready  out  1           read address ready
// - s_axi_araddr   in   ADDR_WIDTH  byte address of first beat
// - s_axi_arlen    in   8           beats-1
// - s_axi_arsize   in   3           bytes per beat, log2
// - s_axi_arburst  in   2           0=FIXED 1=INCR 2=WRAP 3=reserved
// - s_axi_rvalid   out  1           read data valid
// - s_axi_rready   in   1           initiator ready for data
// - s_axi_rdata    out  DATA_WIDTH  beat data
// - s_axi_rresp    out  2           0=OKAY, 2=SLVERR
// - s_axi_rlast    out  1           final beat of the burst
// - mem_we         in   1           backdoor write enable
// - mem_waddr      in   log2(MEM_WORDS)  backdoor word index
// - mem_wdata      in   DATA_WIDTH  backdoor write data
// BEHAVIOUR
// - Reset: arready=1, rvalid=0, rdata=0, rresp=0, rlast=0, state IDLE, counters 0.
//   Memory contents are not cleared. Reset mid-burst aborts the burst: rvalid=0 on the next
//   cycle and no further beats are issued.
// - FSM IDLE -> WAIT -> BURST -> IDLE. arready=1 only in IDLE.
// - IDLE: on arvalid&&arready, latch addr/len/size/burst, set arready=0, go to WAIT with
//   lat_cnt=READ_LATENCY. If READ_LATENCY=0, go directly to BURST.
// - WAIT: decrement lat_cnt; at 0 go to BURST. The first rvalid occurs exactly READ_LATENCY+1
//   cycles after the AR handshake edge.
// - BURST: rdata/rresp/rlast are registered and stay stable while rvalid && !rready. A beat
//   completes on rvalid&&rready. The next beat is presented the following cycle, so a
//   continuous rready gives one beat per cycle.
// - rlast=1 only when beat_cnt==arlen. After the last handshake: rvalid=0 and arready=1 on the
//   next cycle (IDLE).
// - Word index = araddr[3 +: log2(MEM_WORDS)]; araddr[2:0] is ignored. Upper bits alias
//   (modulo MEM_WORDS).
// - INCR: index+1 per beat, wrapping modulo MEM_WORDS.
// - FIXED: same index every beat.
// - WRAP: len=arlen+1 must be 2/4/8/16. Base = index & ~(len-1). Next = base | ((idx+1)&(len-1)).
// - Error: arsize!=3, arburst==3, or illegal WRAP length -> all arlen+1 beats carry rresp=2,
//   rdata=0, and rlast is still asserted on the final beat.
// - Backdoor write is applied at the clock edge. A beat loaded on that same edge returns the
//   old data. rdata already presented is never altered.
// - arvalid while busy is ignored (arready=0); there is only one outstanding burst.
// CONFIGURATION
// - AXIRD_BUBBLE_EN defined: after every completed beat except the last, rvalid drops for
//   exactly one cycle before the next beat (to stress initiator buffering). Burst of N beats
//   with continuous rready takes 2N-1 cycles.
// - AXIRD_BUBBLE_EN undefined: back-to-back beats, N cycles.
// TESTING
// - Preload mem[i]=64'hA5A5_0000_0000_0000+i for i<16. INCR araddr=0x40, arlen=7, rready=1
//   -> rdata 0x..08..0x..0F, rlast on beat 8 only, rresp=0, first rvalid 3 cycles after AR.
// - WRAP araddr=0x68, arlen=7 -> word order 13,14,15,8,9,10,11,12; rlast on word 12.
// - Same INCR burst with rready toggling 1,0,0,1 -> rdata/rlast held while stalled; 8 beats
//   delivered, none duplicated or lost.
// - arsize=2, arlen=3 -> 4 beats rresp=2, rdata=0, rlast on beat 4; arready=1 the cycle after.
// - Assert reset after beat 3 of an 8-beat burst -> rvalid=0 next cycle, arready=1 after release;
//   a new AR at 0x0 returns mem[0] first.
// - READ_LATENCY=0, FIXED araddr=0x18, arlen=3 -> four beats of mem[3], first rvalid 1 cycle
//   after AR; with AXIRD_BUBBLE_EN, 7 cycles from first to last beat.

Source files
------------

// File: rtl/axi_burst_read_responder.sv
// ---------------------------------------------------------------------------
// axi_burst_read_responder
//
// AXI4 read-channel responder backed by an internal word memory. It accepts
// one read burst at a time on AR, waits READ_LATENCY idle cycles, then returns
// arlen+1 R beats with rlast on the final one. The memory is filled through a
// one-cycle backdoor write port and is never cleared by reset.
//
// Ports
//   clock, reset        rising-edge clock, synchronous active-high reset
//   s_axi_ar*           read address channel (arvalid/arready handshake,
//                       araddr byte address, arlen beats-1, arsize log2
//                       bytes, arburst 0=FIXED 1=INCR 2=WRAP)
//   s_axi_r*            read data channel (rvalid/rready handshake, rdata,
//                       rresp 0=OKAY 2=SLVERR, rlast)
//   mem_we/waddr/wdata  backdoor word write, applied at the clock edge
//   debug_state         current FSM state (IDLE=0, WAIT=1, BURST=2)
//
// Build option
//   AXIRD_BUBBLE_EN     when defined, rvalid drops for one cycle after every
//                       completed beat except the last.
//
// Handshakes: an AR request is accepted on the edge where arvalid && arready
// are both high; an R beat transfers on the edge where rvalid && rready are
// both high. Once rvalid is raised, rdata/rresp/rlast hold until that edge.
// ---------------------------------------------------------------------------
module axi_burst_read_responder #(
    parameter int ADDR_WIDTH   = 64,
    parameter int DATA_WIDTH   = 64,
    parameter int MEM_WORDS    = 1024,
    parameter int READ_LATENCY = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         s_axi_arvalid,
    output logic                         s_axi_arready,
    input  logic [ADDR_WIDTH-1:0]        s_axi_araddr,
    input  logic [7:0]                   s_axi_arlen,
    input  logic [2:0]                   s_axi_arsize,
    input  logic [1:0]                   s_axi_arburst,
    output logic                         s_axi_rvalid,
    input  logic                         s_axi_rready,
    output logic [DATA_WIDTH-1:0]        s_axi_rdata,
    output logic [1:0]                   s_axi_rresp,
    output logic                         s_axi_rlast,
    input  logic                         mem_we,
    input  logic [$clog2(MEM_WORDS)-1:0] mem_waddr,
    input  logic [DATA_WIDTH-1:0]        mem_wdata,
    output logic [1:0]                   debug_state
);

    localparam int IW = $clog2(MEM_WORDS);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_BURST = 2'd2;

    localparam logic [3:0]    LAT_INIT = 4'(READ_LATENCY);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic [1:0]    state;
    logic [3:0]    lat_cnt;
    logic [IW-1:0] idx;        // word index of the next beat to be loaded
    logic [7:0]    len_q;
    logic [7:0]    beat_cnt;   // number of the next beat to be loaded
    logic [1:0]    burst_q;
    logic          err_q;

    logic          ar_err;
    logic          beat_done;
    logic          load_beat;
    logic [IW-1:0] wrap_mask;
    logic [IW-1:0] idx_next;

    // Only the word-index bits of the address matter; low byte bits and
    // upper bits (which alias) are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axi_araddr[ADDR_WIDTH-1:IW+3], s_axi_araddr[2:0]};

    assign debug_state = state;

    always_comb begin
        ar_err = (s_axi_arsize != 3'd3) || (s_axi_arburst == 2'd3) ||
                 ((s_axi_arburst == 2'd2) &&
                  (s_axi_arlen != 8'd1) && (s_axi_arlen != 8'd3) &&
                  (s_axi_arlen != 8'd7) && (s_axi_arlen != 8'd15));
    end

    // Address of the beat after idx. WRAP keeps the upper bits of the
    // aligned block and increments only the bits inside the block.
    always_comb begin
        wrap_mask = IW'(len_q[3:0]);
        idx_next  = idx;
        case (burst_q)
            2'd1:    idx_next = idx + IDX_ONE;
            2'd2:    idx_next = (idx & ~wrap_mask) | ((idx + IDX_ONE) & wrap_mask);
            default: idx_next = idx;
        endcase
    end

    // A new beat is loaded whenever the output register is empty, or (without
    // bubbles) on the same edge a non-final beat is consumed.
    always_comb begin
        beat_done = s_axi_rvalid && s_axi_rready;
`ifdef AXIRD_BUBBLE_EN
        load_beat = (state == ST_BURST) && !s_axi_rvalid;
`else
        load_beat = (state == ST_BURST) &&
                    (!s_axi_rvalid || (beat_done && !s_axi_rlast));
`endif
    end

    // Backdoor write; a beat loaded on the same edge sees the old word.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            lat_cnt       <= '0;
            idx           <= '0;
            len_q         <= '0;
            beat_cnt      <= '0;
            burst_q       <= '0;
            err_q         <= 1'b0;
            s_axi_arready <= 1'b1;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= 2'd0;
            s_axi_rlast   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (s_axi_arvalid && s_axi_arready) begin
                        idx           <= s_axi_araddr[3 +: IW];
                        len_q         <= s_axi_arlen;
                        burst_q       <= s_axi_arburst;
                        err_q         <= ar_err;
                        beat_cnt      <= '0;
                        s_axi_arready <= 1'b0;
                        if (READ_LATENCY == 0) begin
                            state <= ST_BURST;
                        end else begin
                            state   <= ST_WAIT;
                            lat_cnt <= LAT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    // Leaving at 1 rather than 0 accounts for the cycle BURST
                    // spends loading the first beat into the output register.
                    if (lat_cnt <= 4'd1) begin
                        state   <= ST_BURST;
                        lat_cnt <= '0;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                ST_BURST: begin
                    if (load_beat) begin
                        s_axi_rvalid <= 1'b1;
                        s_axi_rdata  <= err_q ? '0 : mem[idx];
                        s_axi_rresp  <= err_q ? 2'd2 : 2'd0;
                        s_axi_rlast  <= (beat_cnt == len_q);
                        idx          <= idx_next;
                        beat_cnt     <= beat_cnt + 8'd1;
                    end else if (beat_done) begin
                        s_axi_rvalid <= 1'b0;
                        if (s_axi_rlast) begin
                            state         <= ST_IDLE;
                            s_axi_arready <= 1'b1;
                            s_axi_rlast   <= 1'b0;
                            s_axi_rresp   <= 2'd0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_burst_read_responder.sv
// ---------------------------------------------------------------------------
// tb_axi_burst_read_responder
//
// Bench for axi_burst_read_responder. A main instance (READ_LATENCY=2) runs a
// table of bursts plus reset-abort and backdoor-write sequences; a second
// instance (READ_LATENCY=0) runs a FIXED burst to check zero latency and beat
// spacing. Expected beats come from a reference memory image and an
// address-sequence model, queued when the AR request is issued.
// ---------------------------------------------------------------------------
module tb_axi_burst_read_responder;

    localparam int MW = 1024;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          rr;       // 0 = rready high, 1 = rready pattern 1,0,0,1
        bit          err;
        int          first_w;
        int          last_w;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [63:0] s_axi_araddr = '0;
    logic [7:0]  s_axi_arlen = '0;
    logic [2:0]  s_axi_arsize = 3'd3;
    logic [1:0]  s_axi_arburst = 2'd1;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b1;
    logic [63:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;
    logic        mem_we = 1'b0;
    logic [9:0]  mem_waddr = '0;
    logic [63:0] mem_wdata = '0;
    logic [1:0]  debug_state;

    logic        z_arvalid = 1'b0;
    logic        z_arready;
    logic [63:0] z_araddr = '0;
    logic [7:0]  z_arlen = '0;
    logic [2:0]  z_arsize = 3'd3;
    logic [1:0]  z_arburst = 2'd0;
    logic        z_rvalid;
    logic        z_rready = 1'b1;
    logic [63:0] z_rdata;
    logic [1:0]  z_rresp;
    logic        z_rlast;
    logic        z_mem_we = 1'b0;
    logic [9:0]  z_mem_waddr = '0;
    logic [63:0] z_mem_wdata = '0;
    logic [1:0]  z_debug_state;

    axi_burst_read_responder #(.READ_LATENCY(2)) dut (
        .clock(clock), .reset(reset),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .mem_we(mem_we), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .debug_state(debug_state)
    );

    axi_burst_read_responder #(.READ_LATENCY(0)) dut_z (
        .clock(clock), .reset(reset),
        .s_axi_arvalid(z_arvalid), .s_axi_arready(z_arready),
        .s_axi_araddr(z_araddr), .s_axi_arlen(z_arlen),
        .s_axi_arsize(z_arsize), .s_axi_arburst(z_arburst),
        .s_axi_rvalid(z_rvalid), .s_axi_rready(z_rready),
        .s_axi_rdata(z_rdata), .s_axi_rresp(z_rresp),
        .s_axi_rlast(z_rlast), .mem_we(z_mem_we), .mem_waddr(z_mem_waddr),
        .mem_wdata(z_mem_wdata), .debug_state(z_debug_state)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- bench state ----------------
    logic [63:0] mem_model [MW];
    logic [66:0] exp_q[$];          // {rresp, rlast, rdata}
    vec_t        vecs[12];

    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          rr_mode = 0;       // 2 = rready driven directly by the sequence
    logic [3:0]  pat = 4'b1001;

    bit          stall_pend = 0;
    logic [66:0] stall_word = '0;
    bit          arready_chk = 0;
    bit          ar_seen = 0;
    int          ar_cyc = 0;
    bit          seen_first = 0;
    int          first_cyc = 0;
    int          beat_n = 0;
    bit          done = 0;
    logic [63:0] first_data = '0;
    logic [63:0] last_data = '0;

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic [66:0] got;
        logic [66:0] e;
        if (reset) begin
            stall_pend = 0;
            return;
        end
        got = {s_axi_rresp, s_axi_rlast, s_axi_rdata};
        if (stall_pend)
            check("stall_hold", 128'({s_axi_rvalid, got}), 128'({1'b1, stall_word}));
        stall_pend = s_axi_rvalid && !s_axi_rready;
        stall_word = got;
        if (arready_chk) begin
            check("idle_after_last", 128'({s_axi_arready, s_axi_rvalid}), 128'(2'b10));
            arready_chk = 0;
        end
        if (s_axi_arvalid && s_axi_arready) begin
            ar_seen = 1;
            ar_cyc  = cyc + 1;
        end
        if (s_axi_rvalid) begin
            if (!seen_first) begin
                seen_first = 1;
                first_cyc  = cyc;
            end
            check("arready_busy", 128'(s_axi_arready), 128'(0));
            if (s_axi_rready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_beat: got %0h, expected no beat", got);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", 128'(got), 128'(e));
                end
                if (beat_n == 0) first_data = s_axi_rdata;
                last_data = s_axi_rdata;
                beat_n++;
                if (s_axi_rlast) begin
                    done = 1;
                    arready_chk = 1;
                end
            end
        end
    endtask

    // One clock: observe at the falling edge, then drive 1 time unit after
    // the rising edge.
    task automatic step();
        @(negedge clock);
        monitor();
        @(posedge clock);
        cyc++;
        #1;
        if (rr_mode == 0) s_axi_rready = 1'b1;
        else if (rr_mode == 1) s_axi_rready = pat[cyc % 4];
    endtask

    // ---------------- reference model ----------------
    task automatic push_model(input logic [63:0] a, input logic [7:0] l,
                              input logic [2:0] s, input logic [1:0] b);
        int  start, n, base, w;
        bit  err;
        start = int'(a[12:3]);
        n     = int'(l) + 1;
        err   = (s != 3'd3) || (b == 2'd3) ||
                ((b == 2'd2) && !(n == 2 || n == 4 || n == 8 || n == 16));
        base  = start - (start % n);
        for (int k = 0; k < n; k++) begin
            if (b == 2'd0) w = start;
            else if (b == 2'd1) w = (start + k) % MW;
            else w = base + ((start - base + k) % n);
            if (err) exp_q.push_back({2'b10, (k == n - 1), 64'd0});
            else exp_q.push_back({2'b00, (k == n - 1), mem_model[w]});
        end
    endtask

    // ---------------- drivers ----------------
    task automatic send_ar(input logic [63:0] a, input logic [7:0] l,
                           input logic [2:0] s, input logic [1:0] b);
        beat_n = 0;
        seen_first = 0;
        done = 0;
        ar_seen = 0;
        s_axi_araddr  = a;
        s_axi_arlen   = l;
        s_axi_arsize  = s;
        s_axi_arburst = b;
        s_axi_arvalid = 1'b1;
        for (int i = 0; i < 50 && !ar_seen; i++) step();
        s_axi_arvalid = 1'b0;
        if (!ar_seen) begin
            n_vec++;
            n_bad++;
            $display("FAIL ar_timeout: got no arready, expected handshake");
        end
    endtask

    task automatic wait_first();
        for (int i = 0; i < 50 && !seen_first; i++) step();
        check("first_beat_seen", 128'(seen_first), 128'(1));
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 300 && !done; i++) step();
        check({name, "_done"}, 128'(done), 128'(1));
        check({name, "_queue_empty"}, 128'(exp_q.size()), 128'(0));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [63:0] old16, old17, old19, n16, n17, n18, z3;
        int z_first, z_last, z_beats;

        vecs[0]  = '{64'h40,          8'd7,  3'd3, 2'd1, 0, 1'b0, 8,    15};
        vecs[1]  = '{64'h68,          8'd7,  3'd3, 2'd2, 0, 1'b0, 13,   12};
        vecs[2]  = '{64'h40,          8'd7,  3'd3, 2'd1, 1, 1'b0, 8,    15};
        vecs[3]  = '{64'h0,           8'd3,  3'd2, 2'd1, 0, 1'b1, 0,    0};
        vecs[4]  = '{64'h18,          8'd3,  3'd3, 2'd0, 1, 1'b0, 3,    3};
        vecs[5]  = '{64'h1FF0,        8'd3,  3'd3, 2'd1, 0, 1'b0, 1022, 1};
        vecs[6]  = '{64'h40,          8'd1,  3'd3, 2'd3, 0, 1'b1, 0,    0};
        vecs[7]  = '{64'h40,          8'd2,  3'd3, 2'd2, 0, 1'b1, 0,    0};
        vecs[8]  = '{64'h3C8,         8'd3,  3'd3, 2'd2, 1, 1'b0, 121,  120};
        vecs[9]  = '{64'h1_0000_0010, 8'd0,  3'd3, 2'd1, 0, 1'b0, 2,    2};
        vecs[10] = '{64'h128,         8'd15, 3'd3, 2'd2, 0, 1'b0, 37,   36};
        vecs[11] = '{64'h45,          8'd0,  3'd3, 2'd1, 0, 1'b0, 8,    8};

        // Reset state
        reset = 1'b1;
        step();
        step();
        check("rst_arready", 128'(s_axi_arready), 128'(1));
        check("rst_rvalid", 128'(s_axi_rvalid), 128'(0));
        check("rst_rbeat", 128'({s_axi_rresp, s_axi_rlast, s_axi_rdata}), 128'(0));
        check("rst_state", 128'({debug_state, z_debug_state}), 128'(0));
        reset = 1'b0;

        // Preload both memories
        z3 = 64'h0123_4567_89AB_CDEF;
        for (int i = 0; i < MW; i++) begin
            mem_model[i] = (i < 16) ? (64'hA5A5_0000_0000_0000 + 64'(i))
                                    : {$urandom(), $urandom()};
            mem_we    = 1'b1;
            mem_waddr = 10'(i);
            mem_wdata = mem_model[i];
            z_mem_we    = (i == 0);
            z_mem_waddr = 10'd3;
            z_mem_wdata = z3;
            step();
        end
        mem_we   = 1'b0;
        z_mem_we = 1'b0;
        step();

        // Table of bursts
        for (int v = 0; v < 12; v++) begin
            rr_mode = vecs[v].rr;
            push_model(vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst);
            send_ar(vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst);
            wait_done($sformatf("v%0d", v));
            check($sformatf("v%0d_beats", v), 128'(beat_n), 128'(int'(vecs[v].len) + 1));
            check($sformatf("v%0d_first", v), 128'(first_data),
                  128'(vecs[v].err ? 64'd0 : mem_model[vecs[v].first_w]));
            check($sformatf("v%0d_last", v), 128'(last_data),
                  128'(vecs[v].err ? 64'd0 : mem_model[vecs[v].last_w]));
            check($sformatf("v%0d_latency", v), 128'(first_cyc - ar_cyc), 128'(3));
            rr_mode = 0;
            step();
            step();
        end

        // Backdoor writes around a presented beat and a beat being loaded
        old16 = mem_model[16];
        old17 = mem_model[17];
        old19 = mem_model[19];
        n16 = 64'hDEAD_0000_0000_0016;
        n17 = 64'hDEAD_0000_0000_0017;
        n18 = 64'hDEAD_0000_0000_0018;
        exp_q.push_back({2'b00, 1'b0, old16});
`ifdef AXIRD_BUBBLE_EN
        exp_q.push_back({2'b00, 1'b0, n17});
`else
        exp_q.push_back({2'b00, 1'b0, old17});
`endif
        exp_q.push_back({2'b00, 1'b0, n18});
        exp_q.push_back({2'b00, 1'b1, old19});
        rr_mode = 2;
        s_axi_rready = 1'b0;
        send_ar(64'h80, 8'd3, 3'd3, 2'd1);
        wait_first();
        mem_we = 1'b1; mem_waddr = 10'd16; mem_wdata = n16;
        step();
        mem_waddr = 10'd17; mem_wdata = n17; s_axi_rready = 1'b1;
        step();
        mem_waddr = 10'd18; mem_wdata = n18; s_axi_rready = 1'b0;
        step();
        mem_we = 1'b0;
        mem_model[16] = n16;
        mem_model[17] = n17;
        mem_model[18] = n18;
        rr_mode = 0;
        s_axi_rready = 1'b1;
        wait_done("bdw");
        check("bdw_first", 128'(first_data), 128'(old16));
        step();

        // Reset after beat 3 of an 8-beat burst
        rr_mode = 2;
        s_axi_rready = 1'b0;
        push_model(64'h0, 8'd7, 3'd3, 2'd1);
        send_ar(64'h0, 8'd7, 3'd3, 2'd1);
        wait_first();
        s_axi_rready = 1'b1;
        step();
        step();
        step();
        reset = 1'b1;
        s_axi_rready = 1'b0;
        step();
        check("rst_mid_rvalid", 128'(s_axi_rvalid), 128'(0));
        check("rst_mid_beats", 128'(beat_n), 128'(3));
        check("rst_mid_left", 128'(exp_q.size()), 128'(5));
        exp_q.delete();
        reset = 1'b0;
        rr_mode = 0;
        s_axi_rready = 1'b1;
        repeat (4) step();
        check("rst_mid_arready", 128'({s_axi_arready, s_axi_rvalid}), 128'(2'b10));
        push_model(64'h0, 8'd0, 3'd3, 2'd1);
        send_ar(64'h0, 8'd0, 3'd3, 2'd1);
        wait_done("post_rst");
        check("post_rst_data", 128'(first_data), 128'(mem_model[0]));
        step();

        // Zero-latency FIXED burst on the second instance
        z_araddr = 64'h18; z_arlen = 8'd3; z_arsize = 3'd3; z_arburst = 2'd0;
        z_rready = 1'b1;
        check("z_arready_idle", 128'(z_arready), 128'(1));
        z_arvalid = 1'b1;
        step();
        z_arvalid = 1'b0;
        check("z_rvalid_k0", 128'(z_rvalid), 128'(0));
        z_first = -1;
        z_last  = -1;
        z_beats = 0;
        for (int k = 1; k <= 30 && z_last < 0; k++) begin
            step();
            if (z_rvalid) begin
                check("z_beat", 128'({z_rresp, z_rlast, z_rdata}),
                      128'({2'b00, (z_beats == 3), z3}));
                if (z_first < 0) z_first = k;
                if (z_rlast) z_last = k;
                z_beats++;
            end
        end
        check("z_first_k", 128'(z_first), 128'(1));
`ifdef AXIRD_BUBBLE_EN
        check("z_span", 128'(z_last - z_first), 128'(6));
`else
        check("z_span", 128'(z_last - z_first), 128'(3));
`endif
        check("z_beats", 128'(z_beats), 128'(4));
        step();
        check("z_idle_after", 128'({z_arready, z_rvalid}), 128'(2'b10));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
